// File: rtl/mem_seq_if.sv
// rtl/mem_seq_if.sv - request/memory bus bundle between a requester, mem_seq and the memory
interface mem_seq_if #(
    parameter int DW = 32
);
    logic          Req;
    logic          Wr;
    logic [DW-1:0] Addr;
    logic [DW-1:0] WData;
    logic [DW-1:0] MemRData;
    logic          MemReady;
    logic          MemEn;
    logic          MemWe;
    logic [DW-1:0] MemAddr;
    logic [DW-1:0] MemWData;
    logic [DW-1:0] RData;
    logic          Busy;
    logic          Done;
    logic          Error;

    modport master (
        output Req, Wr, Addr, WData, MemRData, MemReady,
        input  MemEn, MemWe, MemAddr, MemWData, RData, Busy, Done, Error
    );

    modport slave (
        input  Req, Wr, Addr, WData, MemRData, MemReady,
        output MemEn, MemWe, MemAddr, MemWData, RData, Busy, Done, Error
    );
endinterface

// File: rtl/mem_seq.sv
// rtl/mem_seq.sv - single-access memory sequencer with alignment check, timeout and MDR
module mem_seq #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic      Clk,
    input  logic      Reset,
    mem_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          mem_en_q, mem_we_q, busy_q, done_q, error_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.Req) begin
                    // A misaligned request is rejected without touching the latches.
                    if (bus.Addr[1:0] == 2'b00) begin
                        state_d = ACCESS;
                        addr_d  = bus.Addr;
                        wdata_d = bus.WData;
                        wr_d    = bus.Wr;
                        cnt_d   = '0;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            ACCESS: begin
                if (bus.MemReady) begin
                    state_d = DONE;
                    if (!wr_q) begin
                        rdata_d = bus.MemRData;
                    end
                end else if (cnt_q == LAST_CNT) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they behave as pure state decodes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            mem_en_q <= (state_d == ACCESS);
            mem_we_q <= (state_d == ACCESS) && wr_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
            error_q  <= (state_d == ERR);
        end
    end

    assign bus.MemEn    = mem_en_q;
    assign bus.MemWe    = mem_we_q;
    assign bus.MemAddr  = addr_q;
    assign bus.MemWData = wdata_q;
    assign bus.RData    = rdata_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Error    = error_q;
endmodule

// File: tb/tb_mem_seq.sv
// tb/tb_mem_seq.sv - scoreboard bench for mem_seq with a wait-state memory model
module tb_mem_seq;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    mem_seq_if #(.DW(32)) bus ();

    mem_seq #(.DW(32), .TIMEOUT(15)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    typedef struct {
        bit          is_err;
        int          en;
        int          we;
        int          busy;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   ready_on = 0;
    bit   idle_ready = 1'b0;

    function automatic exp_t mk(bit is_err, int en, int we, int busy,
                                logic [31:0] rdata, logic [31:0] addr, logic [31:0] wdata);
        exp_t e;
        e.is_err = is_err; e.en = en; e.we = we; e.busy = busy;
        e.rdata = rdata; e.addr = addr; e.wdata = wdata;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: raises MemReady on the ready_on-th ACCESS cycle (0 = never).
    int acc_n = 0;
    always @(negedge Clk) begin
        if (Reset || !bus.MemEn) begin
            acc_n = 0;
            bus.MemReady = idle_ready;
        end else begin
            acc_n++;
            bus.MemReady = (acc_n == ready_on);
        end
    end

    int          busy_c = 0, en_c = 0, we_c = 0;
    bit          unstable = 1'b0;
    logic [31:0] a0, w0;
    always @(negedge Clk) begin
        exp_t e;
        if (Reset) begin
            busy_c = 0; en_c = 0; we_c = 0; unstable = 1'b0;
        end else begin
            if (bus.Busy) busy_c++;
            if (bus.MemEn) begin
                if (en_c == 0) begin
                    a0 = bus.MemAddr;
                    w0 = bus.MemWData;
                end else if (bus.MemAddr !== a0 || bus.MemWData !== w0) begin
                    unstable = 1'b1;
                end
                en_c++;
                if (bus.MemWe) we_c++;
            end
            if (bus.Done || bus.Error) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious: got Done=%0b Error=%0b expected no completion",
                             bus.Done, bus.Error);
                end else begin
                    e = q.pop_front();
                    check("kind_error", 32'(bus.Error), 32'(e.is_err));
                    check("memen_cycles", en_c, e.en);
                    check("memwe_cycles", we_c, e.we);
                    check("busy_cycles", busy_c, e.busy);
                    check("rdata", bus.RData, e.rdata);
                    check("memaddr", bus.MemAddr, e.addr);
                    check("memwdata", bus.MemWData, e.wdata);
                    check("stable", 32'(unstable), 32'd0);
                end
                busy_c = 0; en_c = 0; we_c = 0; unstable = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.Busy && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (bus.Busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got Busy=1 expected 0 within 100 cycles");
        end
    endtask

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] mrdata, input int rdy, input bit push, input exp_t e);
        wait_idle();
        @(negedge Clk);
        ready_on     = rdy;
        bus.MemRData = mrdata;
        bus.Wr       = wr;
        bus.Addr     = addr;
        bus.WData    = wdata;
        bus.Req      = 1'b1;
        if (push) q.push_back(e);
        @(posedge Clk);
        #1 bus.Req = 1'b0;
    endtask

    initial begin
        exp_t none;
        none = mk(0, 0, 0, 0, 0, 0, 0);
        bus.Req = 1'b0; bus.Wr = 1'b0; bus.Addr = '0; bus.WData = '0; bus.MemRData = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_memen", 32'(bus.MemEn), 0);
        check("rst_memwe", 32'(bus.MemWe), 0);
        check("rst_busy", 32'(bus.Busy), 0);
        check("rst_done", 32'(bus.Done), 0);
        check("rst_error", 32'(bus.Error), 0);
        check("rst_rdata", bus.RData, 0);
        check("rst_memaddr", bus.MemAddr, 0);
        check("rst_memwdata", bus.MemWData, 0);
        Reset = 1'b0;

        issue(0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1,
              mk(0, 1, 0, 2, 32'hDEADBEEF, 32'h100, 32'h0));
        issue(1, 32'h200, 32'h12345678, 32'h0BADF00D, 4, 1,
              mk(0, 4, 4, 5, 32'hDEADBEEF, 32'h200, 32'h12345678));
        issue(0, 32'h300, 32'h11111111, 32'h22222222, 0, 1,
              mk(1, 15, 0, 16, 32'hDEADBEEF, 32'h300, 32'h11111111));
        issue(0, 32'h400, 32'h33333333, 32'hA5A50F0F, 15, 1,
              mk(0, 15, 0, 16, 32'hA5A50F0F, 32'h400, 32'h33333333));
        idle_ready = 1'b1;
        issue(1, 32'h102, 32'h44444444, 32'h55555555, 1, 1,
              mk(1, 0, 0, 1, 32'hA5A50F0F, 32'h400, 32'h33333333));
        wait_idle();
        idle_ready = 1'b0;

        // Abandon an access with reset in its second cycle.
        issue(0, 32'h500, 32'h66666666, 32'h77777777, 0, 0, none);
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("midrst_memen", 32'(bus.MemEn), 0);
        check("midrst_memwe", 32'(bus.MemWe), 0);
        check("midrst_busy", 32'(bus.Busy), 0);
        check("midrst_rdata", bus.RData, 0);
        check("midrst_memaddr", bus.MemAddr, 0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        issue(0, 32'h600, 32'h88888888, 32'hCAFEF00D, 2, 1,
              mk(0, 2, 0, 3, 32'hCAFEF00D, 32'h600, 32'h88888888));
        @(negedge Clk);
        bus.Addr = 32'h103;
        bus.Req  = 1'b1;
        @(negedge Clk);
        bus.Req  = 1'b0;
        wait_idle();

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge Clk);
        repeat (3) @(negedge Clk);
        check("queue_drained", q.size(), 0);
        check("final_busy", 32'(bus.Busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_seq.md
MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 The module SHALL have parameter DW, default 32: data and address width in bits.
REQ-002 The module SHALL have parameter TIMEOUT, default 15: maximum number of ACCESS cycles allowed, legal range 1..255.
REQ-003 The module SHALL have port Clk, input, 1 bit: clock; all state changes occur on its rising edge.
REQ-004 The module SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port Req, input, 1 bit: request an access; sampled only in IDLE.
REQ-006 The module SHALL have port Wr, input, 1 bit: 1 = write, 0 = read; qualified by Req.
REQ-007 The module SHALL have port Addr, input, DW bits: byte address from the IorD mux.
REQ-008 The module SHALL have port WData, input, DW bits: store data (B register).
REQ-009 The module SHALL have port MemRData, input, DW bits: read data from memory.
REQ-010 The module SHALL have port MemReady, input, 1 bit: memory completes the current access this cycle.
REQ-011 The module SHALL have port MemEn, output, 1 bit: memory access strobe.
REQ-012 The module SHALL have port MemWe, output, 1 bit: memory write enable.
REQ-013 The module SHALL have port MemAddr, output, DW bits: latched address to memory.
REQ-014 The module SHALL have port MemWData, output, DW bits: latched write data to memory.
REQ-015 The module SHALL have port RData, output, DW bits: memory data register (MDR) holding the last completed read.
REQ-016 The module SHALL have port Busy, output, 1 bit: high whenever the module is not in IDLE.
REQ-017 The module SHALL have port Done, output, 1 bit: one-cycle pulse on successful completion.
REQ-018 The module SHALL have port Error, output, 1 bit: one-cycle pulse on misalignment or timeout.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, ACCESS, DONE, ERR.
REQ-020 All outputs except RData, MemAddr and MemWData SHALL be decoded from the current state only (Moore).
REQ-021 In IDLE with Req=1 and Addr[1:0]=00, the module SHALL latch Addr, WData and Wr, clear the cycle counter, and enter ACCESS.
REQ-022 In IDLE with Req=1 and Addr[1:0]!=00, the module SHALL enter ERR; no memory strobe SHALL be issued and no latched register SHALL change.
REQ-023 In IDLE with Req=0, the module SHALL remain in IDLE.
REQ-024 Req SHALL be ignored in ACCESS, DONE and ERR; it is neither queued nor latched.
REQ-025 In ACCESS, MemEn SHALL be 1, MemWe SHALL equal the latched Wr, and MemAddr/MemWData SHALL hold the latched values, stable throughout the access.
REQ-026 In ACCESS with MemReady=1, the module SHALL enter DONE; for a read, it SHALL load MemRData into RData on the same edge.
REQ-027 Writes SHALL never modify RData.
REQ-028 In ACCESS with MemReady=0, the cycle counter SHALL increment by one.
REQ-029 When the counter reaches TIMEOUT-1 with MemReady=0, the module SHALL enter ERR on that edge, giving at most TIMEOUT ACCESS cycles.
REQ-030 MemReady=1 in the final allowed ACCESS cycle SHALL take priority over timeout, and the module SHALL enter DONE.
REQ-031 The counter SHALL be 8 bits and SHALL NOT wrap, because timeout exits ACCESS first.
REQ-032 DONE SHALL assert Done=1 and Busy=1 for exactly one cycle, then go to IDLE.
REQ-033 ERR SHALL assert Error=1 and Busy=1 for exactly one cycle, then go to IDLE.
REQ-034 MemEn and MemWe SHALL be 0 in IDLE, DONE and ERR.
REQ-035 Minimum latency SHALL be Req accepted at edge N, MemEn high in cycle N+1, Done in cycle N+2 when MemReady=1 in the first ACCESS cycle.
REQ-036 MemReady outside ACCESS SHALL be ignored.

Reset
REQ-037 Reset=1 SHALL immediately force state IDLE, counter 0, RData 0, MemAddr 0, MemWData 0, and the latched Wr 0.
REQ-038 As a consequence of REQ-037, MemEn, MemWe, Busy, Done and Error SHALL all be 0 during reset.
REQ-039 Reset asserted mid-ACCESS SHALL drop MemEn and MemWe asynchronously and abandon the access, with no Done or Error pulse.
REQ-040 After Reset deasserts, the first Req SHALL be accepted on the next rising edge.

Verification
REQ-041 The bench SHALL cover read with zero wait: Req=1, Wr=0, Addr=0x100, MemReady=1 in first ACCESS cycle, MemRData=0xDEADBEEF -> RData=0xDEADBEEF, Done pulse exactly 2 cycles after acceptance.
REQ-042 The bench SHALL cover write with 3 wait states: Req=1, Wr=1, Addr=0x200, WData=0x12345678, MemReady on 4th ACCESS cycle -> MemWe=1 for 4 cycles with stable MemAddr/MemWData, Done pulse, RData unchanged.
REQ-043 The bench SHALL cover timeout: TIMEOUT=15, MemReady held 0 -> exactly 15 MemEn cycles, then one Error pulse, then IDLE.
REQ-044 The bench SHALL cover the boundary case: MemReady=1 exactly on the 15th ACCESS cycle -> Done, no Error.
REQ-045 The bench SHALL cover misaligned access: Addr=0x102 -> Error one cycle after acceptance, MemEn never asserted.
REQ-046 The bench SHALL cover mid-access reset: Reset pulsed during the 2nd ACCESS cycle -> MemEn drops at once, no Done or Error; a new read then completes normally.
